// File: rtl/ebpc_dec_merge.sv
// EBPC decoder merge stage: rebuilds the original element stream from the
// decoded zero/nonzero flag stream and the BPC nonzero value stream, and
// swallows the zero padding that completes the final BPC block of a stream.
module ebpc_dec_merge #(
    parameter int DATA_W     = 8,
    parameter int BLOCK_SIZE = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              znz_i,
    input  logic              znz_last_i,
    input  logic              znz_vld_i,
    output logic              znz_rdy_o,
    input  logic [DATA_W-1:0] bpc_data_i,
    input  logic              bpc_vld_i,
    output logic              bpc_rdy_o,
    output logic [DATA_W-1:0] data_o,
    output logic              last_o,
    output logic              vld_o,
    input  logic              rdy_i,
    output logic              idle_o
);

    localparam int CNT_W = $clog2(BLOCK_SIZE);

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;

    // Position inside the current BPC block; wraps naturally since
    // BLOCK_SIZE is a power of two.
    logic [CNT_W-1:0]  blk_cnt_q;
    logic [CNT_W-1:0]  blk_cnt_inc;
    logic              cnt_en;

    // Output register load request and payload.
    logic              out_free;
    logic              load;
    logic [DATA_W-1:0] load_data;
    logic              load_last;

    // Output register (stage p1).
    logic [DATA_W-1:0] data_p1;
    logic              last_p1;
    logic              vld_p1;

    assign blk_cnt_inc = blk_cnt_q + CNT_W'(1);
    assign out_free    = ~vld_p1 | rdy_i;

    // Next-state, handshake and output-load decisions.
    always_comb begin
        state_d   = state_q;
        znz_rdy_o = 1'b0;
        bpc_rdy_o = 1'b0;
        load      = 1'b0;
        load_data = '0;
        load_last = 1'b0;
        cnt_en    = 1'b0;

        case (state_q)
            RUN: begin
                if (znz_vld_i && out_free) begin
                    if (!znz_i) begin
                        // Zero element: reinserted without touching BPC.
                        znz_rdy_o = 1'b1;
                        load      = 1'b1;
                        load_last = znz_last_i;
                        if (znz_last_i && (blk_cnt_q != '0)) begin
                            state_d = DRAIN;
                        end
                    end else if (bpc_vld_i) begin
                        // Nonzero element: flag and value consumed together,
                        // otherwise both sides stall.
                        znz_rdy_o = 1'b1;
                        bpc_rdy_o = 1'b1;
                        load      = 1'b1;
                        load_data = bpc_data_i;
                        load_last = znz_last_i;
                        cnt_en    = 1'b1;
                        if (znz_last_i && (blk_cnt_inc != '0)) begin
                            state_d = DRAIN;
                        end
                    end
                end
            end

            DRAIN: begin
                // Discard block padding until the block boundary.
                bpc_rdy_o = 1'b1;
                if (bpc_vld_i) begin
                    cnt_en = 1'b1;
                    if (blk_cnt_inc == '0) begin
                        state_d = RUN;
                    end
                end
            end

            default: begin
                state_d = RUN;
            end
        endcase
    end

    // State and block counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= RUN;
            blk_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (cnt_en) begin
                blk_cnt_q <= blk_cnt_inc;
            end
        end
    end

    // ---- stage p1: single-entry output register ----
    // Load on accept, clear on pop without load, hold while stalled.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            last_p1 <= 1'b0;
        end else if (load) begin
            vld_p1  <= 1'b1;
            data_p1 <= load_data;
            last_p1 <= load_last;
        end else if (rdy_i) begin
            vld_p1  <= 1'b0;
        end
    end

    assign data_o = data_p1;
    assign last_o = last_p1;
    assign vld_o  = vld_p1;
    assign idle_o = (state_q == RUN) && (blk_cnt_q == '0) && !vld_p1;

endmodule
